// File: rtl/clock_divider_mc_if.sv
// Bundle of per-channel control inputs and divided-clock outputs for clock_divider_mc.
//   master : drives enable/div_value/duty_value/mode/sync_start, observes clk_out/period_tick
//   slave  : the divider itself
// Channel i occupies bit i of the CHANNELS-wide vectors and [i*WIDTH +: WIDTH] of the packed fields.
interface clock_divider_mc_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS*WIDTH-1:0] div_value;
    logic [CHANNELS*WIDTH-1:0] duty_value;
    logic [CHANNELS-1:0]       mode;
    logic                      sync_start;
    logic [CHANNELS-1:0]       clk_out;
    logic [CHANNELS-1:0]       period_tick;

    modport master (
        output enable, div_value, duty_value, mode, sync_start,
        input  clk_out, period_tick
    );

    modport slave (
        input  enable, div_value, duty_value, mode, sync_start,
        output clk_out, period_tick
    );
endinterface

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..div_act and produces either a toggling clock (half-period
// div_act+1) or a duty-cycled clock (period div_act+1, high for duty_act cycles),
// plus a one-cycle period_tick at every period start. Configuration is sampled only
// at a wrap, so mid-period input changes never glitch the output.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : clock_divider_mc_if slave (enable, div_value, duty_value, mode,
//              sync_start in; clk_out, period_tick out, both straight from flops)
module clock_divider_mc #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    clock_divider_mc_if.slave bus
);

    logic [WIDTH-1:0]    r_cnt      [CHANNELS];
    logic [WIDTH-1:0]    r_div_act  [CHANNELS];
    logic [WIDTH-1:0]    r_duty_act [CHANNELS];
    logic [CHANNELS-1:0] r_mode_act;
    logic [CHANNELS-1:0] r_clk_out;
    logic [CHANNELS-1:0] r_period_tick;

    logic [WIDTH-1:0]    w_cnt_nxt      [CHANNELS];
    logic [WIDTH-1:0]    w_div_nxt      [CHANNELS];
    logic [WIDTH-1:0]    w_duty_nxt     [CHANNELS];
    logic [CHANNELS-1:0] w_mode_nxt;
    logic [CHANNELS-1:0] w_clk_nxt;
    logic [CHANNELS-1:0] w_tick_nxt;
    logic [CHANNELS-1:0] w_wrap;

    // Next-state for every channel: disable > wrap (sync or terminal count) > count
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_cnt_nxt[i]  = r_cnt[i];
            w_div_nxt[i]  = r_div_act[i];
            w_duty_nxt[i] = r_duty_act[i];
            w_mode_nxt[i] = r_mode_act[i];
            w_clk_nxt[i]  = r_clk_out[i];
            w_tick_nxt[i] = 1'b0;
            w_wrap[i]     = (r_cnt[i] >= r_div_act[i]) || bus.sync_start;

            if (!bus.enable[i]) begin
                // div_act cleared so the first enabled edge wraps and loads config
                w_cnt_nxt[i]  = '0;
                w_div_nxt[i]  = '0;
                w_duty_nxt[i] = '0;
                w_clk_nxt[i]  = 1'b0;
            end else if (w_wrap[i]) begin
                w_cnt_nxt[i]  = '0;
                w_div_nxt[i]  = bus.div_value[i*WIDTH +: WIDTH];
                w_duty_nxt[i] = bus.duty_value[i*WIDTH +: WIDTH];
                w_mode_nxt[i] = bus.mode[i];
                w_tick_nxt[i] = 1'b1;
                if (bus.mode[i]) begin
                    // cnt_next is 0, so high whenever the new duty is non-zero
                    w_clk_nxt[i] = (bus.duty_value[i*WIDTH +: WIDTH] != '0);
                end else if (bus.sync_start) begin
                    // sync forces a known phase instead of toggling
                    w_clk_nxt[i] = 1'b1;
                end else begin
                    w_clk_nxt[i] = ~r_clk_out[i];
                end
            end else begin
                // cnt < div_act here, so the increment cannot overflow
                w_cnt_nxt[i] = r_cnt[i] + WIDTH'(1);
                if (r_mode_act[i]) begin
                    w_clk_nxt[i] = (w_cnt_nxt[i] < r_duty_act[i]);
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i]      <= '0;
                r_div_act[i]  <= '0;
                r_duty_act[i] <= '0;
            end
            r_mode_act    <= '0;
            r_clk_out     <= '0;
            r_period_tick <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i]      <= w_cnt_nxt[i];
                r_div_act[i]  <= w_div_nxt[i];
                r_duty_act[i] <= w_duty_nxt[i];
            end
            r_mode_act    <= w_mode_nxt;
            r_clk_out     <= w_clk_nxt;
            r_period_tick <= w_tick_nxt;
        end
    end

    assign bus.clk_out     = r_clk_out;
    assign bus.period_tick = r_period_tick;

endmodule

// File: tb/tb_clock_divider_mc.sv
// Self-checking bench for clock_divider_mc: a period-level reference model predicts
// each edge's outputs into a queue; a monitor pops and compares after every edge.
module tb_clock_divider_mc;

    localparam int unsigned W = 8;
    localparam int unsigned C = 4;

    typedef struct packed {
        logic [C-1:0] clk;
        logic [C-1:0] tick;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    clock_divider_mc_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    clock_divider_mc #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;
    int n_pop   = 0;
    exp_t exp_q[$];

    // stimulus configuration
    logic [C-1:0] en_r;
    int           cfg_div  [C];
    int           cfg_duty [C];
    bit           cfg_mode [C];

    // reference model: where each channel sits inside its current period
    bit m_run   [C];
    int m_pos   [C];
    int m_len   [C];
    int m_duty  [C];
    bit m_mode  [C];
    bit m_level [C];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            m_run[c]   = 1'b0;
            m_level[c] = 1'b0;
        end
    endtask

    // One clock edge of behaviour, derived from the period/duty rules
    task automatic model_edge(input bit sync, output exp_t e);
        e = '0;
        for (int c = 0; c < C; c++) begin
            if (!en_r[c]) begin
                m_run[c]   = 1'b0;
                m_level[c] = 1'b0;
            end else if (!m_run[c] || sync || m_pos[c] == m_len[c] - 1) begin
                m_run[c]  = 1'b1;
                m_pos[c]  = 0;
                m_len[c]  = cfg_div[c] + 1;
                m_duty[c] = cfg_duty[c];
                m_mode[c] = cfg_mode[c];
                if (m_mode[c])  m_level[c] = (m_duty[c] > 0);
                else if (sync)  m_level[c] = 1'b1;
                else            m_level[c] = ~m_level[c];
                e.tick[c] = 1'b1;
            end else begin
                m_pos[c] = m_pos[c] + 1;
                if (m_mode[c]) m_level[c] = (m_pos[c] < m_duty[c]);
            end
            e.clk[c] = m_level[c];
        end
    endtask

    task automatic drive(input bit sync);
        exp_t e;
        bus.enable     = en_r;
        bus.sync_start = sync;
        for (int c = 0; c < C; c++) begin
            bus.div_value[c*W +: W]  = W'(cfg_div[c]);
            bus.duty_value[c*W +: W] = W'(cfg_duty[c]);
            bus.mode[c]              = cfg_mode[c];
        end
        model_edge(sync, e);
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic step(input bit sync);
        @(negedge clk);
        drive(sync);
    endtask

    // step, then wait until just after the edge that consumes it
    task automatic step_s(input bit sync);
        step(sync);
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_clk_out", int'(bus.clk_out), 0);
        check("async_rst_tick", int'(bus.period_tick), 0);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_hold_clk_out", int'(bus.clk_out), 0);
        reset_n = 1'b1;
        drive(1'b0);
    endtask

    task automatic set_cfg(input int c, input int dv, input int dt, input bit md);
        cfg_div[c]  = dv;
        cfg_duty[c] = dt;
        cfg_mode[c] = md;
    endtask

    // monitor: one prediction per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                check("clk_out", int'(bus.clk_out), int'(e.clk));
                check("period_tick", int'(bus.period_tick), int'(e.tick));
            end
        end
    end

    initial begin
        bit sync;
        int c;
        int r;
        reset_n        = 1'b0;
        en_r           = '0;
        bus.enable     = '0;
        bus.div_value  = '0;
        bus.duty_value = '0;
        bus.mode       = '0;
        bus.sync_start = 1'b0;
        model_reset();
        #2;
        check("reset_clk_out", int'(bus.clk_out), 0);
        check("reset_tick", int'(bus.period_tick), 0);

        // duty 3/2, toggle div 2, toggle div 0, duty boundary div 255 duty 0
        set_cfg(0, 3, 2, 1'b1);
        set_cfg(1, 2, 0, 1'b0);
        set_cfg(2, 0, 0, 1'b0);
        set_cfg(3, 255, 0, 1'b1);
        en_r = '1;
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step(1'b0);
            @(posedge clk);
            #2;
            check("duty_ch0", int'(bus.clk_out[0]), int'((k % 4) < 2));
            check("duty_tick_ch0", int'(bus.period_tick[0]), int'((k % 4) == 0));
            check("toggle_ch1", int'(bus.clk_out[1]), int'(((k / 3) % 2) == 0));
            check("clkdiv2_ch2", int'(bus.clk_out[2]), int'((k % 2) == 0));
            check("duty0_ch3", int'(bus.clk_out[3]), 0);
        end
        // full 256-cycle period on ch3 with duty 0, then duty 255
        repeat (600) step(1'b0);
        cfg_duty[3] = 255;
        repeat (600) step(1'b0);

        // reload: change ch0 div mid-period, current period must finish unchanged
        set_cfg(0, 7, 4, 1'b1);
        repeat (12) step(1'b0);
        cfg_div[0] = 3;
        repeat (24) step(1'b0);

        // sync: both channels restart in phase
        set_cfg(0, 4, 2, 1'b1);
        set_cfg(1, 9, 0, 1'b0);
        repeat (13) step(1'b0);
        step_s(1'b1);
        check("sync_tick_ch0", int'(bus.period_tick[0]), 1);
        check("sync_tick_ch1", int'(bus.period_tick[1]), 1);
        check("sync_clk_ch1", int'(bus.clk_out[1]), 1);
        repeat (10) step(1'b0);

        // disable ch2 mid-period, then re-enable
        set_cfg(2, 5, 0, 1'b0);
        repeat (9) step(1'b0);
        en_r[2] = 1'b0;
        step_s(1'b0);
        check("disable_clk_ch2", int'(bus.clk_out[2]), 0);
        en_r[2] = 1'b1;
        step_s(1'b0);
        check("reenable_tick_ch2", int'(bus.period_tick[2]), 1);
        repeat (5) step(1'b0);

        async_reset();

        // randomized phase
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                c = int'($urandom_range(0, C - 1));
                r = int'($urandom_range(0, 9));
                if (r < 7)      cfg_div[c] = int'($urandom_range(0, 6));
                else if (r < 9) cfg_div[c] = int'($urandom_range(7, 20));
                else            cfg_div[c] = 255;
                cfg_duty[c] = int'($urandom_range(0, 22));
                if (cfg_duty[c] > 255) cfg_duty[c] = 255;
                cfg_mode[c] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 59) == 0) begin
                c = int'($urandom_range(0, C - 1));
                en_r[c] = ~en_r[c];
            end
            sync = ($urandom_range(0, 49) == 0);
            if (n % 1000 == 999) async_reset();
            else step(sync);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("pop_count", n_pop, n_push);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
